// File: rtl/br_track_ctrl.sv
// Branch tracking controller: keeps in-flight predicted branches in program order, retires them
// against CDB resolutions, trains the predictor and redirects fetch on a mispredict.
module br_track_ctrl #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DEPTH_W      = 3,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               push_valid,
  input  logic [31:0]        push_pc,
  input  logic               push_taken,
  input  logic [31:0]        push_alt_addr,
  output logic               push_ready,
  input  logic               res_valid,
  input  logic [31:0]        res_pc,
  input  logic               res_taken,
  output logic               res_ready,
  output logic               upd_valid,
  output logic [31:0]        upd_pc,
  output logic               upd_taken,
  input  logic               upd_ready,
  output logic               redirect_valid,
  output logic [31:0]        redirect_addr,
  output logic               flush_out,
  output logic [DEPTH_W:0]   count,
  output logic               err_order
);

  localparam int unsigned FcW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [DEPTH_W:0] FullCnt = (DEPTH_W + 1)'(DEPTH);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] front_q, front_d, rear_q, rear_d;
  logic [DEPTH_W:0]   count_q, count_d;
  logic [FcW-1:0]     fcnt_q, fcnt_d;
  logic               upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
  logic [31:0]        upd_pc_q, upd_pc_d, redir_addr_q, redir_addr_d;
  logic               redir_valid_q, redir_valid_d, err_q, err_d;

  logic [31:0] pc_mem [DEPTH];
  logic        taken_mem [DEPTH];
  logic [31:0] alt_mem [DEPTH];

  logic [31:0] head_pc, head_alt;
  logic        head_taken;
  logic        res_fire, hit, mispred, push_fire;

  always_comb begin
    head_pc    = pc_mem[front_q];
    head_taken = taken_mem[front_q];
    head_alt   = alt_mem[front_q];
    push_ready = (state_q == StRun) && (count_q < FullCnt);
    res_ready  = (state_q == StRun) && (count_q != '0) && !(upd_valid_q && !upd_ready);
    res_fire   = rdy_in && res_valid && res_ready;
    hit        = res_fire && (head_pc == res_pc);
    mispred    = hit && (res_taken != head_taken);
    // A flush discards everything, including a push arriving in the same cycle.
    push_fire  = rdy_in && push_valid && push_ready && !mispred;
  end

  always_comb begin
    state_d       = state_q;
    front_d       = front_q;
    rear_d        = rear_q;
    count_d       = count_q;
    fcnt_d        = fcnt_q;
    upd_valid_d   = upd_valid_q;
    upd_pc_d      = upd_pc_q;
    upd_taken_d   = upd_taken_q;
    redir_valid_d = redir_valid_q;
    redir_addr_d  = redir_addr_q;
    err_d         = err_q;
    if (rdy_in) begin
      if (push_fire) rear_d = rear_q + 1'b1;
      if (hit) front_d = front_q + 1'b1;
      unique case ({push_fire, hit})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (res_fire && !hit) err_d = 1'b1;
      if (hit) begin
        upd_valid_d = 1'b1;
        upd_pc_d    = head_pc;
        upd_taken_d = res_taken;
      end else if (upd_valid_q && upd_ready) begin
        upd_valid_d = 1'b0;
      end
      redir_valid_d = mispred;
      if (mispred) begin
        redir_addr_d = head_alt;
        front_d      = '0;
        rear_d       = '0;
        count_d      = '0;
        state_d      = StFlush;
        fcnt_d       = FcW'(FLUSH_CYCLES);
      end
      if (state_q == StFlush) begin
        if (fcnt_q == FcW'(1)) begin
          state_d = StRun;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= StRun;
      front_q       <= '0;
      rear_q        <= '0;
      count_q       <= '0;
      fcnt_q        <= '0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_addr_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      front_q       <= front_d;
      rear_q        <= rear_d;
      count_q       <= count_d;
      fcnt_q        <= fcnt_d;
      upd_valid_q   <= upd_valid_d;
      upd_pc_q      <= upd_pc_d;
      upd_taken_q   <= upd_taken_d;
      redir_valid_q <= redir_valid_d;
      redir_addr_q  <= redir_addr_d;
      err_q         <= err_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && push_fire) begin
      pc_mem[rear_q]    <= push_pc;
      taken_mem[rear_q] <= push_taken;
      alt_mem[rear_q]   <= push_alt_addr;
    end
  end

  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;
  assign redirect_valid = redir_valid_q;
  assign redirect_addr  = redir_addr_q;
  assign flush_out      = (state_q == StFlush);
  assign count          = count_q;
  assign err_order      = err_q;

endmodule
